// File: rtl/tfhe_pbs_scheduler.sv
// tfhe_pbs_scheduler: front-end job scheduler for the PBS engine.
// Two requesters feed a round-robin arbiter into a small job FIFO; jobs are
// issued one at a time on a level start / one-cycle done handshake, and a
// completion record is emitted per job.
// Optional watchdog: define TFHE_SCHED_TIMEOUT_EN.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/ready/addr/len/tag  job descriptor handshake, requester N
//   eng_start/addr/len          level start and job presented to engine
//   eng_busy, eng_done          engine status (unused) and completion pulse
//   cpl_valid/req_id/tag/timeout  one-cycle completion record
//   q_count                     queued jobs, excluding the one in flight
//   sched_busy                  FSM not idle or jobs queued
module tfhe_pbs_scheduler #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          TAG_WIDTH      = 4,
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [DATA_WIDTH-1:0]       req0_addr,
    input  logic [DATA_WIDTH-1:0]       req0_len,
    input  logic [TAG_WIDTH-1:0]        req0_tag,
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [DATA_WIDTH-1:0]       req1_addr,
    input  logic [DATA_WIDTH-1:0]       req1_len,
    input  logic [TAG_WIDTH-1:0]        req1_tag,
    output logic                        eng_start,
    output logic [DATA_WIDTH-1:0]       eng_addr,
    output logic [DATA_WIDTH-1:0]       eng_len,
    input  logic                        eng_busy,
    input  logic                        eng_done,
    output logic                        cpl_valid,
    output logic                        cpl_req_id,
    output logic [TAG_WIDTH-1:0]        cpl_tag,
    output logic                        cpl_timeout,
    output logic [$clog2(FIFO_DEPTH):0] q_count,
    output logic                        sched_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 1 + TAG_WIDTH + 2 * DATA_WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_REARM = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  rearm_q, rearm_d;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q;
    logic                  rr_q;
    logic [DATA_WIDTH-1:0] eng_addr_q, eng_len_q;
    logic                  cur_id_q;
    logic [TAG_WIDTH-1:0]  cur_tag_q;
    logic                  cpl_valid_q, cpl_id_q, cpl_tmo_q;
    logic [TAG_WIDTH-1:0]  cpl_tag_q;

    logic          fifo_full, fifo_empty;
    logic          grant, push, pop, finish, tmo;
    logic [EW-1:0] push_ent, head;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);

    // rr_q names the requester preferred on a tie.
    assign grant      = req1_valid && (!req0_valid || rr_q);
    assign req0_ready = !reset && !fifo_full && !grant;
    assign req1_ready = !reset && !fifo_full && grant;
    assign push       = (req0_valid && req0_ready) ||
                        (req1_valid && req1_ready);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;

    assign push_ent = grant ?
        {1'b1, req1_tag, req1_addr, req1_len} :
        {1'b0, req0_tag, req0_addr, req0_len};
    assign head = mem_q[rd_ptr_q];

`ifdef TFHE_SCHED_TIMEOUT_EN
    logic [31:0] wdog_q;
    logic        unused_busy;

    assign unused_busy = eng_busy;
    // A coincident eng_done wins over the limit.
    assign tmo = (wdog_q == TIMEOUT_CYCLES - 32'd1) && !eng_done;

    // Held at zero outside START, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (reset || state_q != S_START) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 32'd1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{TIMEOUT_CYCLES, eng_busy};
    assign tmo        = 1'b0;
`endif

    assign finish = (state_q == S_START) && (eng_done || tmo);

    always_comb begin
        state_d = state_q;
        rearm_d = rearm_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_START;
            end
            S_START: begin
                if (finish) begin
                    state_d = S_REARM;
                    rearm_d = 1'b0;
                end
            end
            S_REARM: begin
                // Two cycles of start low so the engine re-arms.
                rearm_d = 1'b1;
                if (rearm_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rearm_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            eng_addr_q  <= '0;
            eng_len_q   <= '0;
            cur_id_q    <= 1'b0;
            cur_tag_q   <= '0;
            cpl_valid_q <= 1'b0;
            cpl_id_q    <= 1'b0;
            cpl_tag_q   <= '0;
            cpl_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rearm_q     <= rearm_d;
            cpl_valid_q <= finish;
            cpl_tmo_q   <= finish && !eng_done;
            if (finish) begin
                cpl_id_q  <= cur_id_q;
                cpl_tag_q <= cur_tag_q;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_q     <= !grant;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {cur_id_q, cur_tag_q, eng_addr_q, eng_len_q} <= head;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    assign eng_start   = (state_q == S_START);
    assign eng_addr    = eng_addr_q;
    assign eng_len     = eng_len_q;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_req_id  = cpl_id_q;
    assign cpl_tag     = cpl_tag_q;
    assign cpl_timeout = cpl_tmo_q;
    assign q_count     = cnt_q;
    assign sched_busy  = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_tfhe_pbs_scheduler.sv
// tb_tfhe_pbs_scheduler: randomized scoreboard bench for tfhe_pbs_scheduler.
// Builds with or without TFHE_SCHED_TIMEOUT_EN (watchdog limit set to 16).
module tb_tfhe_pbs_scheduler;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_addr, req0_len, req1_addr, req1_len;
    logic [TW-1:0] req0_tag, req1_tag;
    logic          eng_start, eng_busy, eng_done;
    logic [DW-1:0] eng_addr, eng_len;
    logic          cpl_valid, cpl_req_id, cpl_timeout;
    logic [TW-1:0] cpl_tag;
    logic [2:0]    q_count;
    logic          sched_busy;

    always #5 clk = ~clk;

    tfhe_pbs_scheduler #(
        .DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(32'd16)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_addr(req0_addr), .req0_len(req0_len), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_len(req1_len), .req1_tag(req1_tag),
        .eng_start(eng_start), .eng_addr(eng_addr), .eng_len(eng_len),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .cpl_valid(cpl_valid), .cpl_req_id(cpl_req_id),
        .cpl_tag(cpl_tag), .cpl_timeout(cpl_timeout),
        .q_count(q_count), .sched_busy(sched_busy)
    );

    typedef struct {
        bit            id;
        logic [TW-1:0] tag;
        logic [DW-1:0] addr;
        logic [DW-1:0] len;
        int            acc;
    } job_t;

    typedef struct {
        bit            id;
        logic [TW-1:0] tag;
        bit            tmo;
        int            due;
    } cpl_t;

    job_t jobq[$];
    cpl_t cplq[$];
    bit   acc_log[$];

    int   nvec = 0;
    int   nbad = 0;
    int   cyc = 0;
    int   mq = 0;
    int   last_done = -100;
    int   cur_s = 0;
    int   ntmo = 0;
    bit   ptr = 1'b0;
    bit   prev_start = 1'b0;
    job_t cur;
    bit   hold = 1'b0;
    bit   spur = 1'b0;
    int   dly_fix = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: jobs leave in accept order; a job starts at
    // max(accept+2, previous completion event+4); completion record
    // one cycle after the event.
    always @(negedge clk) begin : mon
        job_t j;
        cpl_t c;
        int   ex;
        bit   g, full, busy_e;
        if (reset) begin
            jobq.delete();
            cplq.delete();
            mq         = 0;
            ptr        = 1'b0;
            last_done  = -100;
            prev_start = 1'b0;
        end else begin
            if (cpl_valid) begin
                if (cplq.size() == 0) begin
                    chk("unexpected cpl_valid", 1, 0);
                end else begin
                    c = cplq.pop_front();
                    chk("cpl cycle", cyc, c.due);
                    chk("cpl_req_id", cpl_req_id, c.id);
                    chk("cpl_tag", cpl_tag, c.tag);
                    chk("cpl_timeout", cpl_timeout, c.tmo);
                    if (cpl_timeout && c.tmo) ntmo++;
                end
            end else if (cplq.size() != 0 && cyc >= cplq[0].due) begin
                c = cplq.pop_front();
                chk("missing cpl_valid", 0, 1);
            end
            if (eng_start && !prev_start) begin
                if (jobq.size() == 0) begin
                    chk("unexpected eng_start", 1, 0);
                end else begin
                    j   = jobq.pop_front();
                    mq--;
                    cur = j;
                    ex  = (j.acc + 2 > last_done + 4) ?
                          j.acc + 2 : last_done + 4;
                    chk("start cycle", cyc, ex);
                    cur_s = cyc;
                end
            end
            if (eng_start && cyc > last_done && cyc <= last_done + 3)
                chk("start during rearm", 1, 0);
            busy_e = eng_start || mq != 0 ||
                     (cyc > last_done && cyc <= last_done + 2);
            chk("sched_busy", sched_busy, busy_e);
            chk("q_count", q_count, mq);
            if (eng_start) begin
                chk("eng_addr", eng_addr, cur.addr);
                chk("eng_len", eng_len, cur.len);
                if (eng_done) begin
                    last_done = cyc;
                    cplq.push_back('{cur.id, cur.tag, 1'b0, cyc + 1});
                end
`ifdef TFHE_SCHED_TIMEOUT_EN
                else if (cyc - cur_s == TMO - 1) begin
                    last_done = cyc;
                    cplq.push_back('{cur.id, cur.tag, 1'b1, cyc + 1});
                end
`endif
            end
            full = (mq >= DEPTH);
            if (req0_valid || req1_valid) begin
                g = (req0_valid && req1_valid) ? ptr : req1_valid;
                if (req0_valid)
                    chk("req0_ready", req0_ready, !full && !g);
                if (req1_valid)
                    chk("req1_ready", req1_ready, !full && g);
            end
            if (req0_valid && req0_ready && req1_valid && req1_ready)
                chk("double accept", 1, 0);
            if (req0_valid && req0_ready) begin
                jobq.push_back('{1'b0, req0_tag, req0_addr, req0_len, cyc});
                acc_log.push_back(1'b0);
                mq++;
                ptr = 1'b1;
            end else if (req1_valid && req1_ready) begin
                jobq.push_back('{1'b1, req1_tag, req1_addr, req1_len, cyc});
                acc_log.push_back(1'b1);
                mq++;
                ptr = 1'b0;
            end
            prev_start = eng_start;
        end
    end

    // Engine model: done a chosen number of cycles after start rises,
    // optional stray done pulses while start is low.
    initial begin : eng
        bit active;
        int cnt;
        active   = 1'b0;
        cnt      = 0;
        eng_done = 1'b0;
        eng_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            eng_done = 1'b0;
            if (reset || !eng_start) begin
                active   = 1'b0;
                eng_busy = 1'b0;
                if (spur && $urandom_range(0, 3) == 0) eng_done = 1'b1;
            end else if (!active) begin
                active   = 1'b1;
                eng_busy = 1'b1;
                cnt = (dly_fix != 0) ? dly_fix : $urandom_range(1, 20);
            end else begin
                if (cnt > 0) cnt--;
                if (cnt == 0 && !hold) eng_done = 1'b1;
            end
        end
    end

    task automatic send(input bit r, input logic [TW-1:0] tag,
                        input logic [DW-1:0] addr, input logic [DW-1:0] len);
        int n;
        if (r) begin
            req1_tag = tag; req1_addr = addr; req1_len = len;
            req1_valid = 1'b1;
        end else begin
            req0_tag = tag; req0_addr = addr; req0_len = len;
            req0_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (!reset && (r ? req1_ready : req0_ready)) break;
            n++;
            if (n > 3000) begin
                chk("accept wait expired", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (r) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            n++;
            if (!sched_busy && !cpl_valid &&
                cplq.size() == 0 && jobq.size() == 0) break;
            if (n > 2000) begin
                chk("drain wait expired", 0, 1);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic rnd_send(input bit r);
        send(r, 4'($urandom), $urandom, $urandom);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin : main
        int t0;
        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req0_len = '0; req0_tag = '0;
        req1_addr = '0; req1_len = '0; req1_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst eng_start", eng_start, 0);
        chk("rst cpl_valid", cpl_valid, 0);
        chk("rst cpl_timeout", cpl_timeout, 0);
        chk("rst q_count", q_count, 0);
        chk("rst sched_busy", sched_busy, 0);
        chk("rst eng_addr", eng_addr, 0);
        chk("rst req0_ready", req0_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single job, done 8 cycles after start
        dly_fix = 8;
        send(1'b0, 4'h3, 32'h1000, 32'h40);
        drain();
        dly_fix = 0;

        // contention: both requesters continuously valid
        acc_log.delete();
        fork
            begin for (int i = 0; i < 4; i++) rnd_send(1'b0); end
            begin for (int i = 0; i < 4; i++) rnd_send(1'b1); end
        join
        drain();
        chk("contention accepts", acc_log.size(), 8);
        for (int i = 1; i < acc_log.size(); i++)
            chk("contention alternation", acc_log[i] != acc_log[i-1], 1);

        // back-pressure: engine stalled, FIFO fills
        hold = 1'b1;
        fork
            begin for (int i = 0; i < 3; i++) rnd_send(1'b0); end
            begin for (int i = 0; i < 3; i++) rnd_send(1'b1); end
        join_none
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp q_count", q_count, 4);
        chk("bp eng_start", eng_start, 1);
        chk("bp pending", req0_valid || req1_valid, 1);
        chk("bp req0_ready", req0_ready, 0);
        chk("bp req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait fork;
        drain();

        // reset while a job is in flight with two queued
        hold = 1'b1;
        for (int i = 0; i < 3; i++) rnd_send(1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre-reset q_count", q_count, 2);
        chk("pre-reset eng_start", eng_start, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset eng_start", eng_start, 0);
        chk("post-reset q_count", q_count, 0);
        chk("post-reset cpl_valid", cpl_valid, 0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        send(1'b1, 4'h9, 32'h2000, 32'h80);
        drain();

        // random traffic with stray done pulses
        spur = 1'b1;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    rnd_send(1'b0);
                end
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk);
                        #1;
                    end
                    rnd_send(1'b1);
                end
            end
        join
        spur = 1'b0;
        drain();

`ifdef TFHE_SCHED_TIMEOUT_EN
        // watchdog: engine never completes
        t0 = ntmo;
        hold = 1'b1;
        rnd_send(1'b0);
        rnd_send(1'b1);
        repeat (60) @(posedge clk);
        #1;
        hold = 1'b0;
        drain();
        chk("timeout completions", ntmo - t0, 2);
`else
        t0 = 0;
        chk("no timeout completions", ntmo + t0, 0);
`endif

        chk("jobs left queued", jobq.size(), 0);
        chk("completions left", cplq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
